cn_bank_ctrl: RTL
=================

# cn_bank_ctrl

Controller that sequences a bank of WIDTH change/no-change flip-flops on behalf of two requesters. It arbitrates round-robin between requesters A and B and accepts one command per grant: hold, set, clear or toggle, applied under a bit mask. It translates each command into per-bit C/N drive using the bank's current Q, then verifies the bank state one cycle later. It sits between the requester logic and an external array of cn_ff instances sharing `clk`.

## Interface
- WIDTH, 8: number of CN flip-flops in the controlled bank (1..32).

Ports:
- clk  in  1  rising-edge clock, shared with the bank.
- reset  in  1  asynchronous, active-low. 0 = reset.
- req_a  in  1  request from A; held high until gnt_a.
- op_a  in  2  command from A: 00 hold, 01 set, 10 clear, 11 toggle.
- mask_a  in  WIDTH  bits A operates on.
- req_b, op_b, mask_b  in  1/2/WIDTH  same as A, for requester B.
- gnt_a, gnt_b  out  1  one-cycle grant pulse; command is latched in this cycle.
- bank_q  in  WIDTH  Q outputs of the bank.
- cn_c  out  WIDTH  C inputs to the bank.
- cn_n  out  WIDTH  N inputs to the bank.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.
- done_id  out  1  owner of the completing command: 0 = A, 1 = B. Valid with done.
- err  out  1  pulse with done when bank_q differs from the expected value.
- err_cnt  out  8  saturating count of err pulses.

## Operation
- CN flip-flop law the controller relies on (next Q per bit):
  - n=0: hold.
  - n=1, c=0: clear to 0.
  - n=1, c=1: toggle.
- Per-bit drive in APPLY, where q = bank_q[i]:
  - mask bit 0, or op hold: n=0, c=0.
  - set: n=~q, c=1.
  - clear: n=1, c=0.
  - toggle: n=1, c=1.
- Expected value, registered in APPLY, per bit:
  - mask 0 or hold: q.
  - set: 1.
  - clear: 0.
  - toggle: ~q.
- FSM states: INIT, IDLE, APPLY, VERIFY.
  - INIT: drive cn_n all ones, cn_c all zeros (clears the bank). Go to IDLE.
  - IDLE: if any request is present, pulse the selected gnt, latch op, mask and owner, go to APPLY. Otherwise stay in IDLE.
  - APPLY: drive cn_c/cn_n per the table above, register the expected value. Go to VERIFY.
  - VERIFY: compare bank_q with the expected value. Pulse done; pulse err and increment err_cnt on mismatch. Go to IDLE.
- Arbitration:
  - Single request: that requester is granted.
  - Both requesting: grant the requester not granted most recently.
  - The pointer updates only on a grant. After reset, A has priority.
- In every state other than INIT and APPLY: cn_c = 0, cn_n = 0, so the bank holds.
- err_cnt saturates at 255 and clears only on reset.
- A request may drop only after its grant. Requests and op/mask are ignored outside IDLE.

## Timing
- While reset = 0:
  - state = INIT, pointer favours A.
  - gnt_a, gnt_b, done, err, done_id = 0; err_cnt = 0.
  - cn_c, cn_n forced to 0; busy = 1.
- First rising edge after reset release is spent in INIT. IDLE is reached on the second edge, so gnt cannot appear before the 2nd cycle after release.
- Per command:
  - Cycle 0 (IDLE): gnt.
  - Cycle 1 (APPLY): drive.
  - The bank updates on the edge ending cycle 1.
  - Cycle 2 (VERIFY): done/err.
- One command per 3 cycles; minimum req-to-done latency is 2 cycles.
- Back-to-back: a request pending at the VERIFY→IDLE edge is granted in the following IDLE cycle.
- Simultaneous req_a and req_b in IDLE: exactly one gnt. The other is granted at the next IDLE if still asserted.
- Reset asserted mid-command:
  - outputs are forced immediately (asynchronous);
  - no done is issued, the command is dropped;
  - the sequence restarts at INIT.
- All outputs are registered except cn_c/cn_n, which are combinational from state, latched command and bank_q.

## Test plan
- Reset release, WIDTH=8, bank preloaded 0xFF:
  - cn_n=0xFF, cn_c=0x00 for exactly one cycle;
  - bank_q=0x00 afterwards; busy falls on the 2nd edge.
- A set, mask 0x0F, bank 0x30:
  - gnt_a at cycle 0; in APPLY cn_n=0x0F, cn_c=0x0F;
  - bank_q=0x3F; done with done_id=0, err=0.
- B toggle, mask 0xA5, bank 0x3F:
  - bank_q=0x9A; done_id=1.
- B clear, mask 0xF0, bank 0x9A:
  - bank_q=0x0A, no err.
- req_a and req_b held high together for 4 commands:
  - grant order A, B, A, B; each gnt is 3 cycles apart.
- Fault injection:
  - bank model forced to ignore bit 0 during a set on mask 0x01 from 0x00 → err=1, err_cnt=1;
  - 300 such commands → err_cnt=255.
- Reset asserted in APPLY:
  - cn_n/cn_c drop to 0 immediately, no done;
  - INIT clear occurs after release.

Source files
------------

// File: rtl/cn_bank_ctrl.sv
// Round-robin controller for a bank of change/no-change flip-flops: grants one
// command per IDLE, drives per-bit C/N from the bank's Q, then checks the result.

module cn_bank_lane (
    input  logic [1:0] op,
    input  logic       mask,
    input  logic       q,
    output logic       c,
    output logic       n,
    output logic       exp_v
);
    always_comb begin
        c     = 1'b0;
        n     = 1'b0;
        exp_v = q;
        if (mask) begin
            case (op)
                2'b01: begin c = 1'b1; n = ~q;  exp_v = 1'b1; end // toggle only bits still at 0
                2'b10: begin c = 1'b0; n = 1'b1; exp_v = 1'b0; end
                2'b11: begin c = 1'b1; n = 1'b1; exp_v = ~q;   end
                default: ;
            endcase
        end
    end
endmodule

module cn_bank_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [1:0]       op_a,
    input  logic [WIDTH-1:0] mask_a,
    input  logic             req_b,
    input  logic [1:0]       op_b,
    input  logic [WIDTH-1:0] mask_b,
    output logic             gnt_a,
    output logic             gnt_b,
    input  logic [WIDTH-1:0] bank_q,
    output logic [WIDTH-1:0] cn_c,
    output logic [WIDTH-1:0] cn_n,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err,
    output logic [7:0]       err_cnt
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_APPLY, S_VERIFY} state_t;

    state_t           state, state_nxt;
    logic             armed;
    logic             prio_b;
    logic             grant_a, grant_b;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic             owner_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] lane_c, lane_n, lane_exp;
    logic             mismatch;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        cn_bank_lane u_lane (
            .op    (op_q),
            .mask  (mask_q[i]),
            .q     (bank_q[i]),
            .c     (lane_c[i]),
            .n     (lane_n[i]),
            .exp_v (lane_exp[i])
        );
    end

    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            // armed delays the bank clear to the first full cycle after release
            S_INIT:   if (armed) state_nxt = S_IDLE;
            S_IDLE: begin
                if (req_a || req_b) begin
                    grant_b   = req_b && (!req_a || prio_b);
                    grant_a   = req_a && !grant_b;
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY:  state_nxt = S_VERIFY;
            S_VERIFY: state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        cn_c = '0;
        cn_n = '0;
        if (state == S_INIT && armed) begin
            cn_n = '1;
        end else if (state == S_APPLY) begin
            cn_c = lane_c;
            cn_n = lane_n;
        end
    end

    assign mismatch = (state == S_VERIFY) && (bank_q != exp_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_INIT;
            armed   <= 1'b0;
            prio_b  <= 1'b0;
            op_q    <= 2'b00;
            mask_q  <= '0;
            owner_q <= 1'b0;
            exp_q   <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            done_id <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            busy  <= (state_nxt != S_IDLE);
            gnt_a <= grant_a;
            gnt_b <= grant_b;
            if (grant_a || grant_b) begin
                op_q    <= grant_b ? op_b : op_a;
                mask_q  <= grant_b ? mask_b : mask_a;
                owner_q <= grant_b;
                prio_b  <= grant_a;
            end
            if (state == S_APPLY) exp_q <= lane_exp;
            done    <= (state == S_VERIFY);
            done_id <= (state == S_VERIFY) && owner_q;
            err     <= mismatch;
            if (mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
